// File: rtl/jtag_shifter_if.sv
// Vector-side and pin-side signals of the bit-serial JTAG shifter.
// master: FIFO stage / target, slave: the shifter itself.
interface jtag_shifter_if;
  logic        ENABLE;
  logic [31:0] TMS_VECTOR;
  logic [31:0] TDI_VECTOR;
  logic [31:0] TDO_VECTOR;
  logic        DONE;
  logic        BUSY;
  logic        TCK;
  logic        TMS;
  logic        TDI;
  logic        TDO;

  modport master (
    output ENABLE,
    output TMS_VECTOR,
    output TDI_VECTOR,
    output TDO,
    input  TDO_VECTOR,
    input  DONE,
    input  BUSY,
    input  TCK,
    input  TMS,
    input  TDI
  );

  modport slave (
    input  ENABLE,
    input  TMS_VECTOR,
    input  TDI_VECTOR,
    input  TDO,
    output TDO_VECTOR,
    output DONE,
    output BUSY,
    output TCK,
    output TMS,
    output TDI
  );
endinterface

// File: rtl/jtag_shifter.sv
// Bit-serial JTAG engine: shifts one TMS/TDI vector pair LSB first
// and captures TDO; TCK comes from CLK through a fixed divider.
module jtag_shifter #(
  parameter int C_NUM_BITS = 32,
  parameter int C_TCK_DIV  = 4
) (
  input logic           CLK,
  input logic           RESET,
  jtag_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    TCK_LO,
    TCK_HI,
    FINISH
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(C_TCK_DIV - 1);
  localparam logic [4:0]  BIT_LAST = 5'(C_NUM_BITS - 1);

  state_t      state_q, state_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [31:0] tdo_vec_q, tdo_vec_d;
  logic [31:0] tms_sr_q, tms_sr_d;
  logic [31:0] tdi_sr_q, tdi_sr_d;
  logic [31:0] tdo_sr_q, tdo_sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        div_last;

  assign div_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    done_d    = done_q;
    busy_d    = busy_q;
    tdo_vec_d = tdo_vec_q;
    tms_sr_d  = tms_sr_q;
    tdi_sr_d  = tdi_sr_q;
    tdo_sr_d  = tdo_sr_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    unique case (state_q)
      IDLE: begin
        tck_d = 1'b0;
        if (bus.ENABLE) begin
          tms_sr_d  = bus.TMS_VECTOR;
          tdi_sr_d  = bus.TDI_VECTOR;
          tms_d     = bus.TMS_VECTOR[0];
          tdi_d     = bus.TDI_VECTOR[0];
          tdo_sr_d  = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = TCK_LO;
        end
      end
      TCK_LO: begin
        if (div_last) begin
          tck_d     = 1'b1;
          div_cnt_d = '0;
          state_d   = TCK_HI;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      TCK_HI: begin
        if (div_last) begin
          // TDO is taken at the end of the high phase
          tck_d               = 1'b0;
          div_cnt_d           = '0;
          tdo_sr_d[bit_cnt_q] = bus.TDO;
          if (bit_cnt_q == BIT_LAST) begin
            tdo_vec_d = tdo_sr_d;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = FINISH;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            tms_sr_d  = tms_sr_q >> 1;
            tdi_sr_d  = tdi_sr_q >> 1;
            tms_d     = tms_sr_q[1];
            tdi_d     = tdi_sr_q[1];
            state_d   = TCK_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      FINISH: begin
        tck_d  = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      tck_q     <= 1'b0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tdo_vec_q <= '0;
      tms_sr_q  <= '0;
      tdi_sr_q  <= '0;
      tdo_sr_q  <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tdo_vec_q <= tdo_vec_d;
      tms_sr_q  <= tms_sr_d;
      tdi_sr_q  <= tdi_sr_d;
      tdo_sr_q  <= tdo_sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign bus.TCK        = tck_q;
  assign bus.TMS        = tms_q;
  assign bus.TDI        = tdi_q;
  assign bus.DONE       = done_q;
  assign bus.BUSY       = busy_q;
  assign bus.TDO_VECTOR = tdo_vec_q;

endmodule

// File: tb/tb_jtag_shifter.sv
// Scoreboard bench for jtag_shifter: three instances cover
// the default, fastest-divider and short-vector configurations.
module tb_jtag_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  jtag_shifter_if b0();
  jtag_shifter_if b1();
  jtag_shifter_if b2();

  jtag_shifter #(.C_NUM_BITS(32), .C_TCK_DIV(4)) u0 (
    .CLK(clk), .RESET(rst0), .bus(b0)
  );
  jtag_shifter #(.C_NUM_BITS(32), .C_TCK_DIV(1)) u1 (
    .CLK(clk), .RESET(rst1), .bus(b1)
  );
  jtag_shifter #(.C_NUM_BITS(8), .C_TCK_DIV(2)) u2 (
    .CLK(clk), .RESET(rst2), .bus(b2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    int          id;
    logic [31:0] tdo;
    int          at;
  } exp_t;
  exp_t sbq[$];

  logic        loop0 = 1'b0;
  logic [31:0] tgt0 = '0;
  logic [31:0] tms_v = '0;
  logic [31:0] tdi_v = '0;
  bit          chk_bits = 1'b0;

  int r0 = 0, r1 = 0, r2 = 0;
  int base0 = 0, base1 = 0, base2 = 0;
  logic tp0 = 1'b0, tp1 = 1'b0, tp2 = 1'b0;
  logic dp0 = 1'b0, dp1 = 1'b0, dp2 = 1'b0;

  logic [4:0] tidx;
  assign tidx = 5'(r0 - base0 - 1);

  // target model: bit k is returned while TCK is high for bit k
  assign b0.TDO = loop0 ? b0.TDI : tgt0[tidx];
  assign b1.TDO = 1'b1;
  assign b2.TDO = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_pop(input int id, input logic [31:0] vec);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_done", 32'(id + 1), 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("done_id", 32'(id), 32'(e.id));
      chk("tdo_vec", vec, e.tdo);
      chk("done_cyc", 32'(cyc), 32'(e.at));
    end
  endtask

  always @(negedge clk) begin
    if (b0.TCK && !tp0) begin
      if (chk_bits) begin
        chk("tms_bit", 32'(b0.TMS), 32'(tms_v[5'(r0 - base0)]));
        chk("tdi_bit", 32'(b0.TDI), 32'(tdi_v[5'(r0 - base0)]));
      end
      r0++;
    end
    if (b1.TCK && !tp1) r1++;
    if (b2.TCK && !tp2) r2++;
    tp0 = b0.TCK;
    tp1 = b1.TCK;
    tp2 = b2.TCK;
    if (b0.DONE && !dp0) sb_pop(0, b0.TDO_VECTOR);
    if (b1.DONE && !dp1) sb_pop(1, b1.TDO_VECTOR);
    if (b2.DONE && !dp2) sb_pop(2, b2.TDO_VECTOR);
    dp0 = b0.DONE;
    dp1 = b1.DONE;
    dp2 = b2.DONE;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sb(input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  int e;
  int n;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    b0.ENABLE = 1'b0;
    b1.ENABLE = 1'b0;
    b2.ENABLE = 1'b0;
    b0.TMS_VECTOR = '0;
    b0.TDI_VECTOR = '0;
    b1.TMS_VECTOR = '0;
    b1.TDI_VECTOR = '0;
    b2.TMS_VECTOR = '0;
    b2.TDI_VECTOR = '0;
    tick(3);
    chk("rst_tck", 32'(b0.TCK), 32'd0);
    chk("rst_tms", 32'(b0.TMS), 32'd0);
    chk("rst_done", 32'(b0.DONE), 32'd0);
    chk("rst_busy", 32'(b0.BUSY), 32'd0);
    chk("rst_tdov", b0.TDO_VECTOR, 32'd0);
    chk("rst_tdov2", b2.TDO_VECTOR, 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    tick(2);

    // loopback, TMS high for the first five bits
    loop0 = 1'b1;
    tms_v = 32'h0000_001F;
    tdi_v = 32'hA5A5_A5A5;
    b0.TMS_VECTOR = tms_v;
    b0.TDI_VECTOR = tdi_v;
    chk_bits = 1'b1;
    base0 = r0;
    b0.ENABLE = 1'b1;
    e = cyc + 1;
    sbq.push_back('{0, 32'hA5A5_A5A5, e + 256});
    tick(1);
    b0.ENABLE = 1'b0;
    chk("busy_start", 32'(b0.BUSY), 32'd1);
    wait_sb(400);
    chk("rises_loop", 32'(r0 - base0), 32'd32);
    chk("busy_end", 32'(b0.BUSY), 32'd0);

    // sticky DONE with ENABLE held high
    b0.ENABLE = 1'b1;
    n = r0;
    tick(100);
    chk("sticky_rises", 32'(r0 - n), 32'd0);
    chk("sticky_done", 32'(b0.DONE), 32'd1);
    chk("sticky_tck", 32'(b0.TCK), 32'd0);

    // bit order, restarted straight out of reset
    loop0 = 1'b0;
    tgt0 = 32'h8000_0000;
    tms_v = 32'h0;
    tdi_v = 32'h1;
    b0.TMS_VECTOR = tms_v;
    b0.TDI_VECTOR = tdi_v;
    rst0 = 1'b1;
    tick(1);
    chk("rst1_done", 32'(b0.DONE), 32'd0);
    chk("rst1_busy", 32'(b0.BUSY), 32'd0);
    chk("rst1_tdov", b0.TDO_VECTOR, 32'd0);
    base0 = r0;
    rst0 = 1'b0;
    e = cyc + 1;
    sbq.push_back('{0, 32'h8000_0000, e + 256});
    tick(1);
    chk("restart_busy", 32'(b0.BUSY), 32'd1);
    b0.ENABLE = 1'b0;
    wait_sb(400);
    chk("rises_order", 32'(r0 - base0), 32'd32);

    // reset in the middle of a shift
    rst0 = 1'b1;
    tick(1);
    rst0 = 1'b0;
    base0 = r0;
    b0.ENABLE = 1'b1;
    e = cyc + 1;
    tick(1);
    b0.ENABLE = 1'b0;
    tick(99);
    rst0 = 1'b1;
    tick(1);
    chk("mid_tck", 32'(b0.TCK), 32'd0);
    chk("mid_busy", 32'(b0.BUSY), 32'd0);
    chk("mid_done", 32'(b0.DONE), 32'd0);
    tick(1);
    rst0 = 1'b0;
    chk("mid_partial", 32'(r0 - base0), 32'd12);
    n = r0;
    tick(100);
    chk("mid_rises", 32'(r0 - n), 32'd0);
    chk("mid_done_late", 32'(b0.DONE), 32'd0);
    chk_bits = 1'b0;

    // fastest divider
    b1.TMS_VECTOR = $urandom;
    b1.TDI_VECTOR = $urandom;
    base1 = r1;
    b1.ENABLE = 1'b1;
    e = cyc + 1;
    sbq.push_back('{1, 32'hFFFF_FFFF, e + 64});
    tick(1);
    b1.ENABLE = 1'b0;
    wait_sb(200);
    chk("rises_fast", 32'(r1 - base1), 32'd32);

    // short vector
    b2.TMS_VECTOR = $urandom;
    b2.TDI_VECTOR = $urandom;
    base2 = r2;
    b2.ENABLE = 1'b1;
    e = cyc + 1;
    sbq.push_back('{2, 32'h0000_00FF, e + 32});
    tick(1);
    wait_sb(200);
    tick(20);
    b2.ENABLE = 1'b0;
    chk("rises_short", 32'(r2 - base2), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
